// File: rtl/osnt_bram_replay.sv
// osnt_bram_replay
//   Replay engine sitting on the read port of the packet UltraRAM. It walks the
//   word range addr_low..addr_high, unpacks each stored word into one AXI4-Stream
//   beat and loops over the range replay_count times (0 = until stopped). A small
//   output FIFO absorbs backpressure. Reads are only issued when the FIFO is
//   guaranteed to have room for the returning word, so nothing is ever dropped.
//
//   Stored word layout (LSB first):
//     tdata | tuser | tkeep | valid | last | unused
//
// Ports
//   axis_aclk, axis_resetn      clock, async active-low reset
//   replay_start, replay_stop   control pulses
//   addr_low, addr_high         inclusive replay range, sampled on start
//   replay_count                loops to run, 0 = infinite, sampled on start
//   bram_*                      RAM port (read-only use; 1-cycle read latency)
//   m_axis_*                    AXI4-Stream master
//   busy, done, loops_done      status
//
// FSM states
//   state    | meaning
//   ST_IDLE  | waiting for an accepted start
//   ST_RUN   | issuing RAM reads, wrapping at addr_high
//   ST_DRAIN | no more reads; emptying the read pipe and the FIFO

module osnt_bram_replay #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 736,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                     axis_aclk,
  input  logic                     axis_resetn,
  input  logic                     replay_start,
  input  logic                     replay_stop,
  input  logic [ADDR_WIDTH-1:0]    addr_low,
  input  logic [ADDR_WIDTH-1:0]    addr_high,
  input  logic [CNT_WIDTH-1:0]     replay_count,
  output logic [ADDR_WIDTH-1:0]    bram_addr,
  output logic                     bram_en,
  output logic                     bram_we,
  output logic [DATA_WIDTH-1:0]    bram_wrdata,
  input  logic [DATA_WIDTH-1:0]    bram_rddata,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_WIDTH-1:0]     loops_done
);

  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int USER_LSB   = TDATA_WIDTH;
  localparam int KEEP_LSB   = USER_LSB + TUSER_WIDTH;
  localparam int VALID_BIT  = KEEP_LSB + KEEP_WIDTH;
  localparam int LAST_BIT   = VALID_BIT + 1;
  localparam int PW         = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t                  state, state_nxt;
  logic                    done_nxt;
  logic [ADDR_WIDTH-1:0]   cfg_low, cfg_high, ptr;
  logic [CNT_WIDTH-1:0]    cfg_count, loops_inc;
  logic                    stop_pend, rd_pend;
  logic                    start_ok, rd_valid, stop_hit, room, issue, wrap, last_loop;
  logic                    push, pop;
  logic [PW+1:0]           occupancy;

  logic [TDATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
  logic [TUSER_WIDTH-1:0]  fifo_user [FIFO_DEPTH];
  logic [KEEP_WIDTH-1:0]   fifo_keep [FIFO_DEPTH];
  logic                    fifo_last [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW:0]             fifo_count;

  logic                    unused_rd_bits;
  assign unused_rd_bits = ^bram_rddata[DATA_WIDTH-1:LAST_BIT+1];

  assign start_ok  = (state == ST_IDLE) && replay_start && (addr_low <= addr_high);
  assign rd_valid  = rd_pend && bram_rddata[VALID_BIT];

  // Stop boundary: the returning word closes a packet while a stop is pending.
  // Issue is suppressed in the same cycle, so nothing is left in flight behind it.
  assign stop_hit  = (state == ST_RUN) && stop_pend && rd_valid && bram_rddata[LAST_BIT];

  // Count the word in flight against FIFO space so its return always fits.
  assign occupancy = {1'b0, fifo_count} + {{(PW+1){1'b0}}, rd_pend};
  assign room      = occupancy < (PW+2)'(FIFO_DEPTH);
  assign issue     = (state == ST_RUN) && room && !stop_hit;
  assign wrap      = issue && (ptr == cfg_high);
  assign loops_inc = (&loops_done) ? loops_done : loops_done + CNT_WIDTH'(1);
  assign last_loop = wrap && (cfg_count != '0) && (loops_inc == cfg_count);

  assign push      = rd_valid;
  assign pop       = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
      ST_RUN:   if (last_loop || stop_hit) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if ((fifo_count == '0) && !rd_pend) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      cfg_low    <= '0;
      cfg_high   <= '0;
      cfg_count  <= '0;
      ptr        <= '0;
      loops_done <= '0;
      stop_pend  <= 1'b0;
      rd_pend    <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= done_nxt;
      rd_pend <= issue;
      if (start_ok) begin
        cfg_low    <= addr_low;
        cfg_high   <= addr_high;
        cfg_count  <= replay_count;
        ptr        <= addr_low;
        loops_done <= '0;
        stop_pend  <= 1'b0;
      end else begin
        if (issue) begin
          ptr <= wrap ? cfg_low : ptr + ADDR_WIDTH'(1);
        end
        if (wrap) begin
          loops_done <= loops_inc;
        end
        if ((state == ST_RUN) && replay_stop) begin
          stop_pend <= 1'b1;
        end else if (state_nxt == ST_IDLE) begin
          stop_pend <= 1'b0;
        end
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage: a push never targets the head entry while it is being presented.
  always_ff @(posedge axis_aclk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bram_rddata[TDATA_WIDTH-1:0];
      fifo_user[wr_ptr] <= bram_rddata[KEEP_LSB-1:USER_LSB];
      fifo_keep[wr_ptr] <= bram_rddata[VALID_BIT-1:KEEP_LSB];
      fifo_last[wr_ptr] <= bram_rddata[LAST_BIT];
    end
  end

  assign bram_en      = issue;
  assign bram_addr    = issue ? ptr : '0;
  assign bram_we      = 1'b0;
  assign bram_wrdata  = '0;

  // Payload is gated so the bus reads zero whenever nothing is presented.
  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_data[rd_ptr] : '0;
  assign m_axis_tuser  = m_axis_tvalid ? fifo_user[rd_ptr] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? fifo_keep[rd_ptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid && fifo_last[rd_ptr];

  assign busy = (state != ST_IDLE);

endmodule
